// File: rtl/lcd_pkg.sv
// Shared types and constants for the 16x2 LCD write scheduler.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        WAIT
    } state_t;

    // Power-up command ROM, issued in this order with RS=0.
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, no cursor
    localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (long)
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam int unsigned INIT_LEN    = 4;
    localparam logic [1:0] INIT_LAST    = 2'(INIT_LEN - 1);

    // Return-home opcodes; together with clear these need the long wait.
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    // Default timing in 100 MHz clock cycles.
    localparam int unsigned DEF_T_PWRUP = 1_600_000;
    localparam int unsigned DEF_T_AS    = 6;
    localparam int unsigned DEF_T_PW    = 25;
    localparam int unsigned DEF_T_H     = 2;
    localparam int unsigned DEF_T_EXEC  = 4000;
    localparam int unsigned DEF_T_LONG  = 160_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

    // Clear and return-home execute far slower than every other command.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] op);
        return !rs && (op == CMD_CLEAR || op == CMD_HOME || op == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// Two-port round-robin grant; the pointer only moves on an accepted transfer.
module lcd_rr_arb (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic ptr;  // port that wins when both are valid

    // Lone requester always wins; on contention the pointer decides.
    always_comb begin
        grant[0] = valid[0] & (~valid[1] | ~ptr);
        grant[1] = valid[1] & (~valid[0] |  ptr);
    end

    // After serving port n, hand priority to the other port.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~grant[1];
        end
    end

endmodule

// File: rtl/lcd_write_sched.sv
// LCD power-up sequencer and two-port byte-write scheduler with bus timing.
module lcd_write_sched
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = DEF_T_PWRUP,
    parameter int unsigned T_AS    = DEF_T_AS,
    parameter int unsigned T_PW    = DEF_T_PW,
    parameter int unsigned T_H     = DEF_T_H,
    parameter int unsigned T_EXEC  = DEF_T_EXEC,
    parameter int unsigned T_LONG  = DEF_T_LONG
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_data,
    output logic [1:0]  req_ready,
    output logic        init_done,
    output logic        busy,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic [7:0]  lcd_data_out,
    output logic        lcd_data_oe
);

    localparam int unsigned T_MAX =
        max_u(max_u(max_u(T_PWRUP, T_AS), max_u(T_PW, T_H)), max_u(T_EXEC, T_LONG));
    // Counter holds duration-1, so T_MAX-1 is the largest value it must reach.
    localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, load;
    logic [1:0]       init_idx;
    logic [1:0]       grant;
    logic             accept;
    logic             accept_port;

    lcd_rr_arb u_arb (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .valid   (req_valid),
        .accept  (accept),
        .grant   (grant)
    );

    assign req_ready   = (state == IDLE && init_done) ? grant : 2'b00;
    assign accept      = |(req_valid & req_ready);
    assign accept_port = req_ready[1];
    assign busy        = (state != IDLE);
    assign lcd_rw      = 1'b0;

    // Next-state and counter reload value for the state being entered.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        state_next = state;
        load       = '0;
        case (state)
            PWR_WAIT: if (cnt == '0) state_next = INIT;
            INIT:     state_next = SETUP;
            IDLE:     if (accept) state_next = SETUP;
            SETUP:    if (cnt == '0) state_next = EN_HI;
            EN_HI:    if (cnt == '0) state_next = HOLD;
            HOLD:     if (cnt == '0) state_next = WAIT;
            WAIT: begin
                if (cnt == '0) begin
                    state_next = (!init_done && init_idx != INIT_LAST) ? SETUP : IDLE;
                end
            end
            default:  state_next = PWR_WAIT;
        endcase
        case (state_next)
            SETUP:   load = CNT_W'(T_AS - 1);
            EN_HI:   load = CNT_W'(T_PW - 1);
            HOLD:    load = CNT_W'(T_H - 1);
            WAIT:    load = is_long_cmd(lcd_rs, lcd_data_out) ? CNT_W'(T_LONG - 1)
                                                              : CNT_W'(T_EXEC - 1);
            default: load = '0;
        endcase
    end

    // State register and the single down-counter, reloaded on every state entry.
    always_ff @(posedge sys_clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (sys_rst) begin
            state <= PWR_WAIT;
            cnt   <= CNT_W'(T_PWRUP - 1);
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cnt <= load;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Bus pins registered from the next state so E and OE are glitch-free.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lcd_en      <= 1'b0;
            lcd_data_oe <= 1'b0;
        end else begin
            lcd_en      <= (state_next == EN_HI);
            lcd_data_oe <= (state_next inside {SETUP, EN_HI, HOLD});
        end
    end

    // RS/data capture: first ROM entry, accepted requests, then next ROM entries.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lcd_rs       <= 1'b0;
            lcd_data_out <= '0;
            init_idx     <= '0;
            init_done    <= 1'b0;
        end else if (state == INIT) begin
            lcd_rs       <= 1'b0;
            lcd_data_out <= init_rom(2'd0);
            init_idx     <= '0;
        end else if (accept) begin
            lcd_rs       <= req_rs[accept_port];
            lcd_data_out <= accept_port ? req_data[15:8] : req_data[7:0];
        end else if (state == WAIT && cnt == '0 && !init_done) begin
            if (init_idx == INIT_LAST) begin
                init_done <= 1'b1;
            end else begin
                init_idx     <= init_idx + 2'd1;
                lcd_data_out <= init_rom(init_idx + 2'd1);
            end
        end
    end

endmodule

// File: tb/tb_lcd_write_sched.sv
// Scoreboard bench: expected LCD writes are queued at stimulus time and
// popped by a monitor on each rising E strobe.
`timescale 1ns/1ps
module tb_lcd_write_sched;

    localparam int unsigned T_PWRUP = 10;
    localparam int unsigned T_AS    = 2;
    localparam int unsigned T_PW    = 3;
    localparam int unsigned T_H     = 1;
    localparam int unsigned T_EXEC  = 5;
    localparam int unsigned T_LONG  = 20;

    localparam logic [8:0] INIT_SEQ [4] = '{9'h038, 9'h00C, 9'h001, 9'h006};

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_rs;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        init_done;
    logic        busy;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic [7:0]  lcd_data_out;
    logic        lcd_data_oe;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [8:0] exp_q [$];
    int         rise_cyc [$];

    lcd_write_sched #(
        .T_PWRUP (T_PWRUP),
        .T_AS    (T_AS),
        .T_PW    (T_PW),
        .T_H     (T_H),
        .T_EXEC  (T_EXEC),
        .T_LONG  (T_LONG)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .req_valid    (req_valid),
        .req_rs       (req_rs),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .init_done    (init_done),
        .busy         (busy),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_en       (lcd_en),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        forever begin
            @(posedge sys_clk);
            cyc++;
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_init();
        for (int i = 0; i < 4; i++) exp_q.push_back(INIT_SEQ[i]);
    endtask

    // Monitor: pop and compare on every E rising edge, check pulse width and grant exclusivity.
    initial begin : monitor
        logic       en_prev;
        int         width;
        logic [8:0] exp;
        en_prev = 1'b0;
        width   = 0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                en_prev = 1'b0;
                width   = 0;
            end else begin
                if (lcd_en && !en_prev) begin
                    rise_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("unexpected_lcd_write", {23'd0, lcd_rs, lcd_data_out}, 32'h1ff);
                    end else begin
                        exp = exp_q.pop_front();
                        check("lcd_write_rs_data", {23'd0, lcd_rs, lcd_data_out}, {23'd0, exp});
                        check("lcd_oe_during_en", lcd_data_oe, 1);
                    end
                end
                if (lcd_en) width++;
                if (!lcd_en && en_prev) begin
                    check("en_pulse_width", width, T_PW);
                    width = 0;
                end
                en_prev = lcd_en;
                if (&req_valid) check("ready_onehot", ($countones(req_ready) <= 1), 1);
            end
        end
    end

    initial begin : stimulus
        logic found;
        logic bad;

        sys_rst   = 1'b1;
        req_valid = 2'b00;
        req_rs    = 2'b00;
        req_data  = 16'h0000;

        // Reset values.
        repeat (3) tick();
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_lcd_en", lcd_en, 0);
        check("rst_lcd_data", lcd_data_out, 8'h00);
        check("rst_lcd_oe", lcd_data_oe, 0);
        check("rst_ready", req_ready, 2'b00);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 1);

        // Init sequence and init_done timing.
        rise_cyc.delete();
        push_init();
        sys_rst = 1'b0;
        repeat (69) tick();
        check("init_done_early", init_done, 0);
        tick();
        check("init_done_at_69", init_done, 1);
        check("idle_after_init", busy, 0);
        check("init_pulse_count", rise_cyc.size(), 4);
        if (rise_cyc.size() == 4) begin
            check("init_gap_38_0c", rise_cyc[1] - rise_cyc[0], 11);
            check("init_gap_0c_01", rise_cyc[2] - rise_cyc[1], 11);
            check("init_gap_01_06_long", rise_cyc[3] - rise_cyc[2], 26);
        end

        // Single port-0 data write: strobe and busy timing.
        req_rs    = 2'b01;
        req_data  = 16'h0041;
        req_valid = 2'b01;
        exp_q.push_back(9'h141);
        #1;
        check("ready0_accept_cycle", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        for (int k = 0; k <= 11; k++) begin
            check($sformatf("w41_en_k%0d", k), lcd_en, (k >= 2 && k <= 4));
            check($sformatf("w41_busy_k%0d", k), busy, (k <= 10));
            check($sformatf("w41_oe_k%0d", k), lcd_data_oe, (k <= 5));
            if (k < 11) tick();
        end

        // Port 1: clear (long wait) then 0x80 (normal wait).
        req_rs    = 2'b00;
        req_data  = 16'h0100;
        req_valid = 2'b10;
        exp_q.push_back(9'h001);
        #1;
        check("ready1_clear", req_ready, 2'b10);
        tick();
        req_data = 16'h8000;
        exp_q.push_back(9'h080);
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (k == 25) check("ready_after_clear_early", req_ready, 2'b00);
            if (k == 26) check("ready_after_clear_26", req_ready, 2'b10);
        end
        tick();
        req_rs   = 2'b10;
        req_data = 16'h5500;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 10) check("ready_after_80_early", req_ready, 2'b00);
            if (k == 11) check("ready_after_80_11", req_ready, 2'b10);
        end
        // Withdraw the pending request before it is accepted.
        req_valid = 2'b00;
        tick();
        tick();
        check("withdrawn_not_accepted", busy, 0);

        // Both ports valid continuously: grants alternate starting at port 0.
        req_rs    = 2'b11;
        req_data  = 16'h3130;
        req_valid = 2'b11;
        exp_q.push_back(9'h130);
        exp_q.push_back(9'h131);
        exp_q.push_back(9'h130);
        exp_q.push_back(9'h131);
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            for (int t = 0; t < 100; t++) begin
                #1;
                if (|(req_valid & req_ready)) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            check($sformatf("rr_found_%0d", i), found, 1);
            check($sformatf("rr_grant_%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        req_valid = 2'b00;
        for (int t = 0; t < 100 && busy; t++) tick();
        check("rr_done_idle", busy, 0);

        // Reset during EN_HI, with a request held through reset and power-up.
        req_rs    = 2'b01;
        req_data  = 16'h0099;
        req_valid = 2'b01;
        exp_q.push_back(9'h199);
        #1;
        tick();
        req_valid = 2'b00;
        for (int t = 0; t < 20; t++) begin
            if (lcd_en) break;
            tick();
        end
        check("en_before_reset", lcd_en, 1);
        tick();
        sys_rst = 1'b1;
        tick();
        check("midrst_en_low", lcd_en, 0);
        check("midrst_busy", busy, 1);
        check("midrst_oe", lcd_data_oe, 0);
        check("midrst_data", lcd_data_out, 8'h00);
        check("midrst_init_done", init_done, 0);
        req_rs    = 2'b10;
        req_data  = 16'h4200;
        req_valid = 2'b10;
        tick();
        check("ready_in_reset", req_ready, 2'b00);
        push_init();
        exp_q.push_back(9'h142);
        sys_rst = 1'b0;
        bad = 1'b0;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (init_done) break;
            if (req_ready != 2'b00) bad = 1'b1;
        end
        check("reinit_done", init_done, 1);
        check("ready_low_before_init", bad, 0);
        check("ready_first_idle", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        check("accepted_first_idle", busy, 1);
        for (int t = 0; t < 100 && busy; t++) tick();
        check("final_idle", busy, 0);
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_write_sched.md
# lcd_write_sched

Write-only sequencer and two-port arbiter for the 16x2 character LCD (16207 / HD44780-compatible) on the alarm board. Runs the power-up initialisation sequence, then time-multiplexes byte writes from two requesters (port 0: clock/time line, port 1: alarm/status line) onto the LCD bus. It generates RS/RW/E/data timing and command execution delays from cycle counts at the 100 MHz PLL clock. It sits between the alarm control logic and the LCD pins.

## Interface
Parameters:
- T_PWRUP, 1_600_000: cycles waited after reset before the first command (16 ms).
- T_AS, 6: cycles RS/data are stable before E rises.
- T_PW, 25: cycles E is held high.
- T_H, 2: cycles RS/data are held after E falls.
- T_EXEC, 4000: post-write wait for normal commands and data (40 µs).
- T_LONG, 160_000: post-write wait for clear (0x01) and home (0x02/0x03) with RS=0 (1.6 ms).

Ports:
- sys_clk  in  1  single clock, 100 MHz.
- sys_rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port write request.
- req_rs  in  2  per-port RS (0 = command, 1 = data).
- req_data  in  16  per-port byte, port n at [8n+7:8n].
- req_ready  out  2  per-port accept; a transfer occurs on a rising edge where valid and ready are both high.
- init_done  out  1  initialisation complete.
- busy  out  1  high whenever the controller is not in IDLE.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  constant 0 (write-only).
- lcd_en  out  1  LCD enable strobe.
- lcd_data_out  out  8  byte driven to the LCD bus.
- lcd_data_oe  out  1  bus output enable; the top level drives the inout from this signal.

## Operation
- States: PWR_WAIT, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT.
- PWR_WAIT: count T_PWRUP cycles, then go to INIT.
- INIT: issue the internal ROM sequence in order, each as a full SETUP/EN_HI/HOLD/WAIT write with RS=0:
  - 0x38 (8-bit, 2 lines)
  - 0x0C (display on)
  - 0x01 (clear, T_LONG)
  - 0x06 (entry mode)
- After the last init command, enter IDLE and set init_done. init_done stays high until reset.
- IDLE arbitration is 2-way round-robin:
  - A lone valid port is granted.
  - If both ports are valid, the port not served last is granted.
  - The priority pointer resets to port 0 and toggles only on an accepted transfer.
- req_ready[n] = IDLE & init_done & grant[n]. This path is combinational from req_valid; it never depends on the requester seeing ready first.
- The accepted rs/byte are latched into the output registers and held stable until the next accept.
- SETUP (T_AS cycles): lcd_data_oe=1, lcd_en=0.
- EN_HI (T_PW cycles): lcd_en=1.
- HOLD (T_H cycles): lcd_en=0, data still driven.
- WAIT (T_EXEC, or T_LONG when rs=0 and byte ∈ {0x01, 0x02, 0x03}): lcd_data_oe=0, then IDLE.
- Requests arriving before init_done are not accepted; they wait with ready low.
- A single internal down-counter is sized to the largest parameter (21 bits at defaults). It is reloaded on every state entry. A parameter value of 0 is illegal; the minimum is 1.

## Timing
- Reset values: lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data_out=0x00, lcd_data_oe=0, req_ready=0, init_done=0, busy=1. State resets to PWR_WAIT and the pointer to port 0.
- Reset mid-operation: on the edge sampling sys_rst=1, all outputs take their reset values, including lcd_en dropping low immediately. The full init sequence repeats afterwards.
- Per-write occupancy: exactly T_AS+T_PW+T_H+wait cycles from the accept edge to the return to IDLE. The next accept is possible on the first IDLE cycle, so there are no gap cycles.
- Simultaneous valid on both ports in IDLE: exactly one ready is high in that cycle.
- Deasserting valid before acceptance is permitted and has no effect.

## Structure
- Shared package lcd_pkg contains:
  - state enum
  - init ROM constants (0x38, 0x0C, 0x01, 0x06) and INIT_LEN=4
  - long-command opcodes
  - default timing constants
- Sub-module lcd_rr_arb: 2-port round-robin grant with pointer update on accept. The FSM, counter and output registers stay in lcd_write_sched.

## Test plan
All scenarios use T_PWRUP=10, T_AS=2, T_PW=3, T_H=1, T_EXEC=5, T_LONG=20.
- Reset release -> four E pulses carrying 0x38, 0x0C, 0x01, 0x06 with RS=0. Gap after 0x01 is the long wait. init_done rises 69 cycles after the first edge with sys_rst=0.
- Port 0 writes rs=1, 0x41 after init_done -> ready0 high in the accept cycle. lcd_en high for exactly 3 cycles, 2 cycles after accept, with data 0x41 and rs 1. busy for 11 cycles.
- Both ports valid continuously (port 0 0x30, port 1 0x31) -> grants alternate 0,1,0,1 starting with port 0. Never both ready in the same cycle.
- Port 1 writes rs=0, 0x01 -> next ready rises 26 cycles after accept. Write rs=0, 0x80 -> next ready after 11 cycles.
- sys_rst asserted during EN_HI -> lcd_en=0 and busy=1 on the next edge. Init replays in full, and no stale byte is re-issued.
- Valid asserted during PWR_WAIT -> ready stays 0 until init_done. The transfer is accepted on the first IDLE cycle.
